// File: rtl/dma_wrr_arbiter.sv
// -----------------------------------------------------------------------------
// dma_wrr_arbiter
//
// Weighted round-robin arbiter for the DMA channel front end. Picks one of
// NUM_CHAN requesting channels and holds a registered one-hot grant until the
// engine pulses `done`. A channel may keep the bus for up to `weight`
// consecutive bursts before the rotate pointer moves past it.
//
// Optional feature: define DMA_ARB_PRIO_EN to add the hi_prio port. High-class
// requests then win every selection, using their own rotate pointer, and they
// preempt a low-class owner's leftover credit at `done`.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   req          per-channel level request
//   weight       per-channel burst credit, channel i in [i*WGT_W +: WGT_W]
//                (0 behaves as 1, sampled when a new owner is chosen)
//   done         one-cycle pulse: current grantee's burst has finished
//   hi_prio      high-priority class mask (DMA_ARB_PRIO_EN only)
//   grant        registered one-hot grant, zero when idle
//   grant_id     binary index of the grantee, zero when idle
//   grant_valid  registered |grant
// -----------------------------------------------------------------------------
module dma_wrr_arbiter #(
  parameter int NUM_CHAN = 4,
  parameter int ID_W     = 2,
  parameter int WGT_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CHAN-1:0]       req,
  input  logic [NUM_CHAN*WGT_W-1:0] weight,
  input  logic                      done,
`ifdef DMA_ARB_PRIO_EN
  input  logic [NUM_CHAN-1:0]       hi_prio,
`endif
  output logic [NUM_CHAN-1:0]       grant,
  output logic [ID_W-1:0]           grant_id,
  output logic                      grant_valid
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  logic                state_q,  state_d;
  logic [ID_W-1:0]     ptr_q,    ptr_d;
  logic [ID_W-1:0]     owner_q,  owner_d;
  logic [WGT_W-1:0]    credit_q, credit_d;
  logic [NUM_CHAN-1:0] grant_q,  grant_d;
`ifdef DMA_ARB_PRIO_EN
  logic [ID_W-1:0]     hptr_q,     hptr_d;
  logic                owner_hi_q, owner_hi_d;
`endif

  // Returns {found, index} of the first set bit of cand, scanning start,
  // start+1, ... modulo NUM_CHAN. The loop runs from the farthest offset down
  // so the nearest hit is written last; no early exit is needed.
  function automatic logic [ID_W:0] pick(input logic [NUM_CHAN-1:0] cand,
                                         input logic [ID_W-1:0]     start);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    for (int i = NUM_CHAN - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= NUM_CHAN) idx = idx - NUM_CHAN;
      if (cand[idx]) res = {1'b1, ID_W'(idx)};
    end
    return res;
  endfunction

  // Explicit wrap so non-power-of-2 channel counts never reach NUM_CHAN.
  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
    return (idx == ID_W'(NUM_CHAN - 1)) ? '0 : idx + ID_W'(1);
  endfunction

  logic [ID_W:0]    win;
  logic             win_hi;
  logic [WGT_W-1:0] win_wgt;
  logic             keep_owner;
  logic             select;

  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    credit_d = credit_q;
    grant_d  = grant_q;
    select   = 1'b0;

`ifdef DMA_ARB_PRIO_EN
    hptr_d     = hptr_q;
    owner_hi_d = owner_hi_q;
    // Any pending high-class request restricts the contest to that class.
    win_hi     = pick(req & hi_prio, hptr_q) >> ID_W != '0;
    win        = win_hi ? pick(req & hi_prio, hptr_q) : pick(req, ptr_q);
    // A low-class owner forfeits leftover credit when high class is waiting.
    keep_owner = (credit_q != '0) && req[owner_q] && (owner_hi_q || !win_hi);
`else
    win_hi     = 1'b0;
    win        = pick(req, ptr_q);
    keep_owner = (credit_q != '0) && req[owner_q];
`endif

    win_wgt = weight[int'(win[ID_W-1:0]) * WGT_W +: WGT_W];

    case (state_q)
      ST_IDLE: begin
        // done while idle is ignored; only a request starts a grant.
        select = win[ID_W];
      end
      default: begin
        if (done) begin
          if (keep_owner) begin
            credit_d = credit_q - WGT_W'(1);
          end else if (win[ID_W]) begin
            select = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            grant_d  = '0;
            owner_d  = '0;
            credit_d = '0;
          end
        end
      end
    endcase

    if (select) begin
      state_d  = ST_BUSY;
      owner_d  = win[ID_W-1:0];
      grant_d  = NUM_CHAN'(1) << win[ID_W-1:0];
      // Weight 0 grants a single burst, same as weight 1.
      credit_d = (win_wgt == '0) ? '0 : win_wgt - WGT_W'(1);
`ifdef DMA_ARB_PRIO_EN
      owner_hi_d = win_hi;
      if (win_hi) hptr_d = next_idx(win[ID_W-1:0]);
      else        ptr_d  = next_idx(win[ID_W-1:0]);
`else
      ptr_d = next_idx(win[ID_W-1:0]);
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      credit_q <= '0;
      grant_q  <= '0;
`ifdef DMA_ARB_PRIO_EN
      hptr_q     <= '0;
      owner_hi_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
      grant_q  <= grant_d;
`ifdef DMA_ARB_PRIO_EN
      hptr_q     <= hptr_d;
      owner_hi_q <= owner_hi_d;
`endif
    end
  end

  // All three outputs come straight from flops that move on the same edge.
  // owner_q is cleared on the way to idle, so grant_id reads 0 there.
  assign grant       = grant_q;
  assign grant_id    = owner_q;
  assign grant_valid = state_q;

endmodule
